// File: rtl/nf_10g_tx_pkt_gate_pkg.sv
// rtl/nf_10g_tx_pkt_gate_pkg.sv - shared types and constants for the 10GE TX packet gate
package nf_10g_tx_gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_KEEP_W  = DEF_DATA_W / 8;
    localparam int DST_PORT_HI = 31;
    localparam int DST_PORT_LO = 24;

    // Buffer entry layout is {tlast, tkeep, tdata}.
    function automatic int entry_width(input int data_w);
        return 1 + data_w / 8 + data_w;
    endfunction

    localparam int DEF_ENTRY_W = entry_width(DEF_DATA_W);

endpackage

// File: rtl/nf_10g_tx_pkt_gate_if.sv
// rtl/nf_10g_tx_pkt_gate_if.sv - AXIS stream bundle with master/slave views
interface nf_10g_tx_pkt_gate_if #(
    parameter int DW = 64,
    parameter int UW = 128
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tlast;
    logic            tvalid;
    logic            tready;

    modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/nf_10g_tx_pkt_gate_ram.sv
// rtl/nf_10g_tx_pkt_gate_ram.sv - simple dual-port RAM with registered read port
module nf_10g_tx_gate_ram #(
    parameter int AW = 9,
    parameter int DW = 73
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end
endmodule

// File: rtl/nf_10g_tx_pkt_gate.sv
// rtl/nf_10g_tx_pkt_gate.sv - store-and-forward TX gate; optional NF_TX_GATE_DST_FILTER_EN drops packets not for this port
module nf_10g_tx_pkt_gate
    import nf_10g_tx_gate_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_FIFO_ADDR_WIDTH  = 9,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                         core_clk,
    input  logic                         core_resetn,
    nf_10g_tx_pkt_gate_if.slave          s_axis,
    nf_10g_tx_pkt_gate_if.master         m_axis,
    input  logic [7:0]                   dst_port_mask,
    input  logic                         clear_counters,
    output logic [C_CNT_WIDTH-1:0]       pkt_out_count,
    output logic [C_CNT_WIDTH-1:0]       pkt_drop_count,
    output logic [C_FIFO_ADDR_WIDTH:0]   fifo_level
);
    localparam int AW      = C_FIFO_ADDR_WIDTH;
    localparam int KEEP_W  = C_AXIS_DATA_WIDTH / 8;
    localparam int ENTRY_W = entry_width(C_AXIS_DATA_WIDTH);
    localparam logic [AW:0]          PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    wr_state_e              r_state;
    logic [AW:0]            r_wr_ptr, r_rd_ptr, r_fetch_ptr, r_commit_ptr, r_pkt_start;
    logic [AW:0]            r_pkt_stored;
    logic [C_CNT_WIDTH-1:0] r_out_count, r_drop_count;
    logic [ENTRY_W-1:0]     r_out, r_skid;
    logic                   r_out_vld, r_skid_vld, r_rd_pend;

    logic                   w_full, w_s_ready, w_s_acc, w_dst_miss, w_wr_en, w_commit;
    logic                   w_overflow, w_drop_evt, w_pop, w_send_done, w_rd_en;
    logic [1:0]             w_occ;
    logic [ENTRY_W-1:0]     w_ram_q;
    logic                   w_unused_sink;

    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_s_ready = core_resetn && ((r_state == ST_DROP) || !w_full);
    assign w_s_acc   = s_axis.tvalid && w_s_ready;

`ifdef NF_TX_GATE_DST_FILTER_EN
    assign w_dst_miss = ((s_axis.tuser[DST_PORT_HI:DST_PORT_LO] & dst_port_mask) == 8'h00);
`else
    assign w_dst_miss = 1'b0;
`endif
    assign w_unused_sink = ^{s_axis.tuser, dst_port_mask};

    assign w_wr_en    = w_s_acc && (r_state != ST_DROP) && !((r_state == ST_IDLE) && w_dst_miss);
    assign w_commit   = w_wr_en && s_axis.tlast;
    assign w_overflow = (r_state == ST_WR) && w_full;
    assign w_drop_evt = w_overflow || ((r_state == ST_IDLE) && w_s_acc && w_dst_miss);

    // Fetch only committed beats; keep at most two beats between RAM and the output.
    assign w_pop       = r_out_vld && m_axis.tready;
    assign w_send_done = w_pop && r_out[ENTRY_W-1];
    assign w_occ       = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_pend} - {1'b0, w_pop};
    assign w_rd_en     = (r_fetch_ptr != r_commit_ptr) && (r_pkt_stored != '0) && (w_occ < 2'd2);

    nf_10g_tx_gate_ram #(
        .AW (AW),
        .DW (ENTRY_W)
    ) u_ram (
        .clk     (core_clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_ptr[AW-1:0]),
        .wr_data ({s_axis.tlast, s_axis.tkeep, s_axis.tdata}),
        .rd_en   (w_rd_en),
        .rd_addr (r_fetch_ptr[AW-1:0]),
        .rd_data (w_ram_q)
    );

    always_ff @(posedge core_clk) begin
        if (!core_resetn) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_pkt_start  <= '0;
            r_commit_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_s_acc) begin
                        if (w_dst_miss) begin
                            if (!s_axis.tlast) r_state <= ST_DROP;
                        end else begin
                            r_pkt_start <= r_wr_ptr;
                            r_wr_ptr    <= r_wr_ptr + PTR_ONE;
                            if (s_axis.tlast) r_commit_ptr <= r_wr_ptr + PTR_ONE;
                            else              r_state      <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (w_overflow) begin
                        r_wr_ptr <= r_pkt_start;
                        r_state  <= ST_DROP;
                    end else if (w_s_acc) begin
                        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                        if (s_axis.tlast) begin
                            r_commit_ptr <= r_wr_ptr + PTR_ONE;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_s_acc && s_axis.tlast) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_resetn) begin
            r_rd_pend   <= 1'b0;
            r_out_vld   <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_fetch_ptr <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_rd_pend <= w_rd_en;
            if (w_rd_en) r_fetch_ptr <= r_fetch_ptr + PTR_ONE;
            if (w_pop)   r_rd_ptr    <= r_rd_ptr + PTR_ONE;
            if (!r_out_vld || w_pop) begin
                if (r_skid_vld) begin
                    r_out      <= r_skid;
                    r_out_vld  <= 1'b1;
                    r_skid     <= w_ram_q;
                    r_skid_vld <= r_rd_pend;
                end else begin
                    r_out      <= w_ram_q;
                    r_out_vld  <= r_rd_pend;
                end
            end else if (r_rd_pend) begin
                r_skid     <= w_ram_q;
                r_skid_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_resetn) begin
            r_pkt_stored <= '0;
            r_out_count  <= '0;
            r_drop_count <= '0;
        end else begin
            case ({w_commit, w_send_done})
                2'b10:   r_pkt_stored <= r_pkt_stored + PTR_ONE;
                2'b01:   r_pkt_stored <= r_pkt_stored - PTR_ONE;
                default: r_pkt_stored <= r_pkt_stored;
            endcase
            if (clear_counters)                        r_out_count <= '0;
            else if (w_send_done && !(&r_out_count))   r_out_count <= r_out_count + CNT_ONE;
            if (clear_counters)                        r_drop_count <= '0;
            else if (w_drop_evt && !(&r_drop_count))   r_drop_count <= r_drop_count + CNT_ONE;
        end
    end

    assign s_axis.tready  = w_s_ready;
    assign m_axis.tvalid  = r_out_vld;
    assign m_axis.tlast   = r_out[ENTRY_W-1];
    assign m_axis.tkeep   = r_out[ENTRY_W-2 -: KEEP_W];
    assign m_axis.tdata   = r_out[C_AXIS_DATA_WIDTH-1:0];
    assign m_axis.tuser   = '0;
    assign pkt_out_count  = r_out_count;
    assign pkt_drop_count = r_drop_count;
    assign fifo_level     = r_wr_ptr - r_rd_ptr;
endmodule

// File: doc/nf_10g_tx_pkt_gate.md
Name: nf_10g_tx_pkt_gate

Overview:
Store-and-forward transmit gate between the NetFPGA pipeline output (AXIS with 128b TUSER) and the 10GE MAC TX AXIS input of the shared-logic interface. The 10GE MAC must never see a tvalid gap mid-frame, so the gate buffers each packet in full before releasing it back-to-back. It discards TUSER, drops packets that exceed buffer capacity, and keeps sent and dropped counters for the register block.

Parameters:
C_AXIS_DATA_WIDTH, 64, tdata width on both sides; tkeep is C_AXIS_DATA_WIDTH/8.
C_AXIS_TUSER_WIDTH, 128, s_axis_tuser width; bits [31:24] are dst_port.
C_FIFO_ADDR_WIDTH, 9, buffer depth is 2^C_FIFO_ADDR_WIDTH beats (512 beats = 4 KiB at 64b).
C_CNT_WIDTH, 32, width of the packet counters.

Ports:
core_clk  in  1  single clock for all logic.
core_resetn  in  1  synchronous, active-low reset.
s_axis_tdata/tkeep/tuser/tlast/tvalid  in  per params  pipeline-side packet stream.
s_axis_tready  out  1  gate can accept a beat.
m_axis_tdata/tkeep/tlast/tvalid  out  per params  MAC TX stream, no tuser.
m_axis_tready  in  1  MAC accepts a beat.
dst_port_mask  in  8  this port's dst_port bits; used only with the optional feature.
clear_counters  in  1  one-cycle pulse that zeroes both counters.
pkt_out_count  out  C_CNT_WIDTH  packets fully sent to the MAC.
pkt_drop_count  out  C_CNT_WIDTH  packets discarded.
fifo_level  out  C_FIFO_ADDR_WIDTH+1  beats currently held.

Behaviour:
- Reset (core_resetn=0 at a clock edge): pointers, level, pkt_stored and counters = 0; write FSM = IDLE; m_axis_tvalid=0; s_axis_tready=0 during reset and 1 from the first cycle after. A reset mid-packet discards all buffered data without counting a drop.
- Write FSM states IDLE, WR, DROP:
  - IDLE: on the first accepted beat, latch pkt_start=wr_ptr, write the beat, go to WR. A single-beat packet (tlast on that beat) commits immediately and stays in IDLE.
  - WR: write each accepted beat. On the tlast beat, commit (pkt_stored+1) and return to IDLE.
  - Overflow while in WR: if the buffer is full and the current packet has no tlast yet, rewind wr_ptr to pkt_start (level drops by the partial length), go to DROP and increment pkt_drop_count.
  - Because rewind plus drop applies whenever full is hit mid-packet, any packet longer than 2^C_FIFO_ADDR_WIDTH beats is dropped.
  - DROP: s_axis_tready=1; beats are accepted and discarded. Return to IDLE after the tlast beat.
- s_axis_tready = !full, except in DROP, where it is 1.
- Read side releases a packet only when pkt_stored>0.
  - First beat: m_axis_tvalid rises 2 cycles after the committing tlast handshake (synchronous RAM read plus output register).
  - Mid-packet: a 2-entry prefetch holds m_axis_tvalid high every cycle until tlast is accepted. The gate never introduces a bubble mid-packet.
  - On the tlast handshake: pkt_stored-1 and pkt_out_count+1.
  - Between packets: the next packet's first beat may follow with zero idle cycles.
  - While m_axis_tvalid=1, tdata/tkeep/tlast hold stable until accepted.
- Simultaneous commit and send-complete in one cycle: pkt_stored is unchanged. Simultaneous write and read in one cycle: level is unchanged.
- Pointers are C_FIFO_ADDR_WIDTH+1 bits with a wrap bit. full = same index with wrap bits different; empty = pointers equal.
- Counters saturate at all-ones. clear_counters wins over a same-cycle increment.
- tkeep passes through unmodified; no checks on tkeep.

Optional Feature:
NF_TX_GATE_DST_FILTER_EN.
- Defined: on the first beat, if (s_axis_tuser[31:24] & dst_port_mask)==0, the FSM goes straight to DROP (nothing written) and pkt_drop_count increments.
- Undefined: dst_port_mask is ignored and all packets are forwarded.

Decomposition:
- Package nf_10g_tx_gate_pkg:
  - write-FSM state enum (IDLE/WR/DROP);
  - localparams for tkeep width and the dst_port bit offsets 31:24;
  - the FIFO entry width, {tlast, tkeep, tdata} = 1+8+64 = 73 bits at defaults.
- Sub-module nf_10g_tx_gate_ram: simple dual-port RAM, 1 write port and 1 registered read port, inferred BRAM.

Test Plan:
- Normal flow: send three 8-beat packets back-to-back with m_axis_tready=1 -> per packet, 8 contiguous valid beats, first beat 2 cycles after its tlast; pkt_out_count=3, pkt_drop_count=0.
- Backpressure: toggle m_axis_tready every cycle -> data/tlast stable while stalled; order preserved; final fifo_level=0.
- Full buffer: hold m_axis_tready=0 and send 4-beat packets -> s_axis_tready=0 at level 512; no drop while each packet fits (512/4=128 packets stored).
- Oversize: send a 600-beat packet with C_FIFO_ADDR_WIDTH=9 -> pkt_drop_count=1, fifo_level returns to 0, nothing appears on m_axis; the next 4-beat packet is sent intact.
- Single-beat packets with clear_counters pulsed in the same cycle as a tlast handshake -> pkt_out_count=0 that cycle, then counts resume from 0.
- With NF_TX_GATE_DST_FILTER_EN defined: dst_port_mask=8'h01, tuser[31:24]=8'h04 -> packet dropped, pkt_drop_count=1; tuser[31:24]=8'h05 -> forwarded.
